stopwatch_lap_ctrl: RTL and testbench
=====================================

STOPWATCH_LAP_CTRL -- requirements
Module: stopwatch_lap_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, counter/lap data width in bits.
REQ-002 Parameter: MAX_COUNT, 5999, last up-count value before wrap; SHALL be < 2^WIDTH.
REQ-003 Parameter: LAP_DEPTH, 4, lap memory entries (>=2).
REQ-004 Port: clk_100  in  1  system clock; one clock domain; all state on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: tick  in  1  one-cycle count-enable strobe.
REQ-007 Port: start_stop  in  1  debounced one-cycle pulse.
REQ-008 Port: lap_reset  in  1  debounced one-cycle pulse.
REQ-009 Port: mode  in  1  0 = count up, 1 = count down; sampled only in IDLE.
REQ-010 Port: load_val  in  WIDTH  down-count start value.
REQ-011 Port: lap_rd  in  1  pop oldest lap entry.
REQ-012 Port: count  out  WIDTH  live counter.
REQ-013 Port: disp_val  out  WIDTH  display value (lap_hold ? held snapshot : count).
REQ-014 Port: running  out  1  high in RUN.
REQ-015 Port: lap_hold  out  1  display frozen on snapshot.
REQ-016 Port: expired  out  1  high in DONE.
REQ-017 Port: lap_data  out  WIDTH  oldest stored lap; 0 when empty.
REQ-018 Port: lap_cnt  out  $clog2(LAP_DEPTH+1)  stored lap entries.
REQ-019 Port: lap_ovf  out  1  sticky; a lap push was dropped.

Function
REQ-020 FSM states IDLE, RUN, PAUSE, DONE; all outputs registered, updating the cycle after the causing input.
REQ-021 IDLE: count loads 0 (mode=0) or load_val (mode=1) every cycle; start_stop -> RUN, or -> DONE if mode=1 and load_val=0.
REQ-022 RUN, mode=0: tick increments count; at MAX_COUNT, tick wraps count to 0, state unchanged.
REQ-023 RUN, mode=1: tick decrements count; tick at count=1 -> count 0, state DONE.
REQ-024 RUN: start_stop -> PAUSE; a tick in the same cycle is still applied.
REQ-025 RUN: lap_reset toggles lap_hold; on 0->1 captures count into hold register and pushes it to lap memory.
REQ-026 PAUSE: count frozen, tick ignored; start_stop -> RUN; lap_reset -> IDLE, clears lap_hold, lap memory, lap_ovf.
REQ-027 DONE: count=0, expired=1; start_stop or lap_reset -> IDLE with lap_hold cleared.
REQ-028 start_stop and lap_reset in the same cycle: start_stop acts, lap_reset ignored.
REQ-029 mode changes outside IDLE ignored; the mode latched on IDLE exit governs the run.
REQ-030 Lap memory FIFO: push when full drops entry and sets lap_ovf; lap_rd when empty ignored; simultaneous push and pop both occur, lap_cnt unchanged.

Reset
REQ-031 On rst: state IDLE, count 0, disp_val 0, running 0, lap_hold 0, expired 0, lap_cnt 0, lap_data 0, lap_ovf 0.
REQ-032 rst asserted mid-RUN SHALL clear all state immediately, without waiting for a clock edge.

Configuration
REQ-033 Macro STOPWATCH_LAP_MEM_EN defined: LAP_DEPTH-entry FIFO with lap_rd/lap_data/lap_cnt/lap_ovf as above.
REQ-034 Macro undefined: no FIFO; lap_rd ignored; lap_data, lap_cnt, lap_ovf tied 0; lap_hold behaviour unchanged.

Verification
REQ-035 mode=0, start_stop, 6001 ticks -> count passes 5999, wraps to 0, ends at 1; running=1.
REQ-036 mode=1, load_val=3, start_stop, 3 ticks -> count 2,1,0; expired=1 the cycle after the third tick; next start_stop -> IDLE, count=3.
REQ-037 RUN at count=10: lap_reset -> lap_hold=1, disp_val=10 while count advances; second lap_reset -> disp_val tracks count.
REQ-038 With macro, LAP_DEPTH=4: 5 lap captures -> lap_cnt=4, lap_ovf=1; lap_rd x4 -> first four snapshots in order, lap_cnt=0, lap_data=0.
REQ-039 start_stop and lap_reset same cycle in PAUSE -> RUN, count and lap memory retained.
REQ-040 rst pulse mid-RUN between clock edges -> all outputs 0 before the next edge; state IDLE.

Source files
------------

// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl
// Stopwatch controller with up/down counting, a lap-hold display snapshot
// and an optional FIFO of lap snapshots.
//
// Optional feature macro: STOPWATCH_LAP_MEM_EN
//   defined   -> LAP_DEPTH-entry lap FIFO drives lap_data/lap_cnt/lap_ovf
//   undefined -> no FIFO; lap_rd ignored; lap_data/lap_cnt/lap_ovf tied 0
//
// Parameters:
//   WIDTH      counter / lap data width
//   MAX_COUNT  last up-count value before wrapping to 0
//   LAP_DEPTH  lap FIFO entries (>= 2)
//
// Ports:
//   clk_100     system clock, all state on rising edge
//   rst         asynchronous active-high reset
//   tick        one-cycle count-enable strobe
//   start_stop  start / pause / resume / acknowledge pulse
//   lap_reset   lap-hold toggle in RUN, clear in PAUSE, acknowledge in DONE
//   mode        0 = count up, 1 = count down (sampled only in IDLE)
//   load_val    down-count start value
//   lap_rd      pop the oldest lap entry
//   count       live counter
//   disp_val    held snapshot while lap_hold, otherwise count
//   running     high in RUN
//   lap_hold    display frozen on snapshot
//   expired     high in DONE
//   lap_data    oldest stored lap, 0 when empty
//   lap_cnt     number of stored laps
//   lap_ovf     sticky: a lap push was dropped because the FIFO was full
module stopwatch_lap_ctrl #(
  parameter int WIDTH     = 16,
  parameter int MAX_COUNT = 5999,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           clk_100,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           start_stop,
  input  logic                           lap_reset,
  input  logic                           mode,
  input  logic [WIDTH-1:0]               load_val,
  input  logic                           lap_rd,
  output logic [WIDTH-1:0]               count,
  output logic [WIDTH-1:0]               disp_val,
  output logic                           running,
  output logic                           lap_hold,
  output logic                           expired,
  output logic [WIDTH-1:0]               lap_data,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_cnt,
  output logic                           lap_ovf
);

  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d, hold_q, hold_d, disp_d;
  logic             mode_q, mode_d, lap_hold_d;
  logic             push, clear_laps;

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count    <= '0;
      mode_q   <= 1'b0;
      lap_hold <= 1'b0;
      hold_q   <= '0;
      disp_val <= '0;
      running  <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      mode_q   <= mode_d;
      lap_hold <= lap_hold_d;
      hold_q   <= hold_d;
      disp_val <= disp_d;
      running  <= (state_d == RUN);
      expired  <= (state_d == DONE);
    end
  end

  // start_stop is evaluated before lap_reset in every state so that it wins
  // when both pulses arrive together. In RUN, a down-count expiry takes
  // priority over a simultaneous pause request.
  always_comb begin
    state_d    = state_q;
    count_d    = count;
    mode_d     = mode_q;
    lap_hold_d = lap_hold;
    hold_d     = hold_q;
    push       = 1'b0;
    clear_laps = 1'b0;
    case (state_q)
      IDLE: begin
        mode_d  = mode;
        count_d = mode ? load_val : '0;
        if (start_stop)
          state_d = (mode && (load_val == '0)) ? DONE : RUN;
      end
      RUN: begin
        if (tick) begin
          if (!mode_q) begin
            count_d = (count == MAX_C) ? '0 : count + WIDTH'(1);
          end else if (count <= WIDTH'(1)) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count - WIDTH'(1);
          end
        end
        if (start_stop) begin
          if (state_d != DONE)
            state_d = PAUSE;
        end else if (lap_reset) begin
          lap_hold_d = !lap_hold;
          if (!lap_hold) begin
            hold_d = count;
            push   = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (start_stop) begin
          state_d = RUN;
        end else if (lap_reset) begin
          state_d    = IDLE;
          lap_hold_d = 1'b0;
          clear_laps = 1'b1;
        end
      end
      DONE: begin
        count_d = '0;
        if (start_stop || lap_reset) begin
          state_d    = IDLE;
          lap_hold_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    disp_d = lap_hold_d ? hold_d : count_d;
  end

`ifdef STOPWATCH_LAP_MEM_EN
  localparam int PW = $clog2(LAP_DEPTH);

  logic [WIDTH-1:0] mem [LAP_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_inc, wr_inc;
  logic [CW-1:0]    lap_cnt_d;
  logic [WIDTH-1:0] lap_data_d;
  logic             pop, push_ok;

  // A pop frees a slot, so a push into a full FIFO in the same cycle is kept.
  assign pop     = lap_rd && (lap_cnt != '0);
  assign push_ok = push && ((lap_cnt != CW'(LAP_DEPTH)) || pop);
  assign rd_inc  = (rd_ptr == PW'(LAP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
  assign wr_inc  = (wr_ptr == PW'(LAP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);

  always_comb begin
    lap_cnt_d = lap_cnt;
    if (push_ok && !pop)
      lap_cnt_d = lap_cnt + CW'(1);
    else if (pop && !push_ok)
      lap_cnt_d = lap_cnt - CW'(1);
  end

  // lap_data is registered, so its next value is the oldest entry after
  // this cycle's push/pop; a push into an otherwise empty FIFO shows at once.
  always_comb begin
    lap_data_d = lap_data;
    if (pop) begin
      if (lap_cnt > CW'(1))
        lap_data_d = mem[rd_inc];
      else if (push_ok)
        lap_data_d = hold_d;
      else
        lap_data_d = '0;
    end else if ((lap_cnt == '0) && push_ok) begin
      lap_data_d = hold_d;
    end
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      lap_cnt  <= '0;
      lap_data <= '0;
      lap_ovf  <= 1'b0;
    end else if (clear_laps) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      lap_cnt  <= '0;
      lap_data <= '0;
      lap_ovf  <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= rd_inc;
      if (push_ok)
        wr_ptr <= wr_inc;
      if (push && !push_ok)
        lap_ovf <= 1'b1;
      lap_cnt  <= lap_cnt_d;
      lap_data <= lap_data_d;
    end
  end

  always_ff @(posedge clk_100) begin
    if (push_ok)
      mem[wr_ptr] <= hold_d;
  end
`else
  logic unused_lap_sigs;
  assign unused_lap_sigs = lap_rd ^ push ^ clear_laps;
  assign lap_data = '0;
  assign lap_cnt  = '0;
  assign lap_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb_stopwatch_lap_ctrl
// Directed self-checking bench for stopwatch_lap_ctrl with default
// parameters (WIDTH=16, MAX_COUNT=5999, LAP_DEPTH=4). Lap FIFO checks are
// selected by STOPWATCH_LAP_MEM_EN; otherwise the lap outputs must stay 0.
module tb_stopwatch_lap_ctrl;

  logic        clk_100 = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap_reset = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] load_val = '0;
  logic        lap_rd = 1'b0;
  logic [15:0] count, disp_val, lap_data;
  logic        running, lap_hold, expired, lap_ovf;
  logic [2:0]  lap_cnt;

  int vectors = 0;
  int miscompares = 0;

  stopwatch_lap_ctrl #(.WIDTH(16), .MAX_COUNT(5999), .LAP_DEPTH(4)) dut (
    .clk_100   (clk_100),
    .rst       (rst),
    .tick      (tick),
    .start_stop(start_stop),
    .lap_reset (lap_reset),
    .mode      (mode),
    .load_val  (load_val),
    .lap_rd    (lap_rd),
    .count     (count),
    .disp_val  (disp_val),
    .running   (running),
    .lap_hold  (lap_hold),
    .expired   (expired),
    .lap_data  (lap_data),
    .lap_cnt   (lap_cnt),
    .lap_ovf   (lap_ovf)
  );

  always #5 clk_100 = ~clk_100;

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap_reset = 1'b1;
    step();
    lap_reset = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if ({count, disp_val} !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_count: count=%0d disp=%0d, expected 0/0", count, disp_val);
    end
    vectors++;
    if ({running, lap_hold, expired, lap_ovf} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: run/hold/exp/ovf=%b, expected 0000",
               {running, lap_hold, expired, lap_ovf});
    end
    vectors++;
    if ({lap_cnt, lap_data} !== 19'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_lap: cnt=%0d data=%0d, expected 0/0", lap_cnt, lap_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_count_up_wrap();
    apply_reset();
    mode = 1'b0;
    pulse_ss();
    vectors++;
    if ({running, count} !== {1'b1, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL up_start: running=%b count=%0d, expected 1/0", running, count);
    end
    do_ticks(5999);
    vectors++;
    if (count !== 16'd5999) begin
      miscompares++;
      $display("[TB] FAIL up_max: count=%0d, expected 5999", count);
    end
    do_ticks(1);
    vectors++;
    if (count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL up_wrap: count=%0d, expected 0", count);
    end
    do_ticks(1);
    vectors++;
    if ({running, expired, count} !== {1'b1, 1'b0, 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL up_after_wrap: running=%b expired=%b count=%0d, expected 1/0/1",
               running, expired, count);
    end
  endtask

  task automatic test_count_down();
    apply_reset();
    mode = 1'b1;
    load_val = 16'd3;
    step();
    vectors++;
    if (count !== 16'd3) begin
      miscompares++;
      $display("[TB] FAIL down_idle_load: count=%0d, expected 3", count);
    end
    pulse_ss();
    vectors++;
    if ({running, count} !== {1'b1, 16'd3}) begin
      miscompares++;
      $display("[TB] FAIL down_start: running=%b count=%0d, expected 1/3", running, count);
    end
    for (int i = 2; i >= 0; i--) begin
      do_ticks(1);
      vectors++;
      if (count !== 16'(i)) begin
        miscompares++;
        $display("[TB] FAIL down_tick: count=%0d, expected %0d", count, i);
      end
    end
    vectors++;
    if ({expired, running, disp_val} !== {1'b1, 1'b0, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL down_expire: expired=%b running=%b disp=%0d, expected 1/0/0",
               expired, running, disp_val);
    end
    do_ticks(2);
    vectors++;
    if ({expired, count} !== {1'b1, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL done_hold: expired=%b count=%0d, expected 1/0", expired, count);
    end
    pulse_ss();
    vectors++;
    if ({expired, running} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL done_exit: expired=%b running=%b, expected 0/0", expired, running);
    end
    step();
    vectors++;
    if (count !== 16'd3) begin
      miscompares++;
      $display("[TB] FAIL down_reload: count=%0d, expected 3", count);
    end
    load_val = 16'd0;
    pulse_ss();
    vectors++;
    if ({expired, running} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL down_zero_load: expired=%b running=%b, expected 1/0", expired, running);
    end
    pulse_lap();
    vectors++;
    if (expired !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_lap_exit: expired=%b, expected 0", expired);
    end
    mode = 1'b0;
  endtask

  task automatic test_lap_hold();
    apply_reset();
    mode = 1'b0;
    pulse_ss();
    do_ticks(10);
    pulse_lap();
    vectors++;
    if ({lap_hold, disp_val, count} !== {1'b1, 16'd10, 16'd10}) begin
      miscompares++;
      $display("[TB] FAIL lap_capture: hold=%b disp=%0d count=%0d, expected 1/10/10",
               lap_hold, disp_val, count);
    end
    do_ticks(3);
    vectors++;
    if ({disp_val, count} !== {16'd10, 16'd13}) begin
      miscompares++;
      $display("[TB] FAIL lap_frozen: disp=%0d count=%0d, expected 10/13", disp_val, count);
    end
    // mode change outside IDLE must not turn the run into a down-count
    mode = 1'b1;
    do_ticks(1);
    mode = 1'b0;
    vectors++;
    if (count !== 16'd14) begin
      miscompares++;
      $display("[TB] FAIL mode_ignored: count=%0d, expected 14", count);
    end
    pulse_lap();
    vectors++;
    if ({lap_hold, disp_val} !== {1'b0, 16'd14}) begin
      miscompares++;
      $display("[TB] FAIL lap_release: hold=%b disp=%0d, expected 0/14", lap_hold, disp_val);
    end
    do_ticks(1);
    vectors++;
    if (disp_val !== 16'd15) begin
      miscompares++;
      $display("[TB] FAIL lap_track: disp=%0d, expected 15", disp_val);
    end
`ifndef STOPWATCH_LAP_MEM_EN
    lap_rd = 1'b1;
    step();
    lap_rd = 1'b0;
    vectors++;
    if ({lap_cnt, lap_data, lap_ovf} !== 20'h0) begin
      miscompares++;
      $display("[TB] FAIL lap_tied: cnt=%0d data=%0d ovf=%b, expected 0/0/0",
               lap_cnt, lap_data, lap_ovf);
    end
`endif
  endtask

  task automatic test_pause_and_same_cycle();
    apply_reset();
    mode = 1'b0;
    pulse_ss();
    do_ticks(5);
    pulse_lap();
    // tick together with start_stop is applied before pausing
    tick = 1'b1;
    start_stop = 1'b1;
    step();
    tick = 1'b0;
    start_stop = 1'b0;
    vectors++;
    if ({running, count} !== {1'b0, 16'd6}) begin
      miscompares++;
      $display("[TB] FAIL stop_with_tick: running=%b count=%0d, expected 0/6", running, count);
    end
    do_ticks(3);
    vectors++;
    if (count !== 16'd6) begin
      miscompares++;
      $display("[TB] FAIL pause_frozen: count=%0d, expected 6", count);
    end
    start_stop = 1'b1;
    lap_reset = 1'b1;
    step();
    start_stop = 1'b0;
    lap_reset = 1'b0;
    vectors++;
    if ({running, lap_hold, count, disp_val} !== {1'b1, 1'b1, 16'd6, 16'd5}) begin
      miscompares++;
      $display("[TB] FAIL both_pulses: run=%b hold=%b count=%0d disp=%0d, expected 1/1/6/5",
               running, lap_hold, count, disp_val);
    end
`ifdef STOPWATCH_LAP_MEM_EN
    vectors++;
    if ({lap_cnt, lap_data} !== {3'd1, 16'd5}) begin
      miscompares++;
      $display("[TB] FAIL both_pulses_mem: cnt=%0d data=%0d, expected 1/5", lap_cnt, lap_data);
    end
`endif
    pulse_ss();
    pulse_lap();
    step();
    vectors++;
    if ({running, lap_hold, count, lap_cnt} !== {1'b0, 1'b0, 16'd0, 3'd0}) begin
      miscompares++;
      $display("[TB] FAIL pause_clear: run=%b hold=%b count=%0d cnt=%0d, expected 0/0/0/0",
               running, lap_hold, count, lap_cnt);
    end
  endtask

`ifdef STOPWATCH_LAP_MEM_EN
  task automatic test_lap_fifo();
    apply_reset();
    mode = 1'b0;
    pulse_ss();
    for (int i = 1; i <= 5; i++) begin
      do_ticks(1);
      pulse_lap();
      pulse_lap();
    end
    vectors++;
    if ({lap_cnt, lap_ovf, lap_data} !== {3'd4, 1'b1, 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL fifo_full: cnt=%0d ovf=%b data=%0d, expected 4/1/1",
               lap_cnt, lap_ovf, lap_data);
    end
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (lap_data !== 16'(i)) begin
        miscompares++;
        $display("[TB] FAIL fifo_order: data=%0d, expected %0d", lap_data, i);
      end
      lap_rd = 1'b1;
      step();
      lap_rd = 1'b0;
    end
    lap_rd = 1'b1;
    step();
    lap_rd = 1'b0;
    vectors++;
    if ({lap_cnt, lap_data, lap_ovf} !== {3'd0, 16'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL fifo_empty: cnt=%0d data=%0d ovf=%b, expected 0/0/1",
               lap_cnt, lap_data, lap_ovf);
    end
    pulse_ss();
    pulse_lap();
    vectors++;
    if (lap_ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear: ovf=%b, expected 0", lap_ovf);
    end
  endtask
`endif

  task automatic test_async_reset();
    apply_reset();
    mode = 1'b0;
    pulse_ss();
    do_ticks(7);
    pulse_lap();
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({count, disp_val, running, lap_hold, expired, lap_cnt, lap_data, lap_ovf} !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: count=%0d disp=%0d run=%b hold=%b exp=%b cnt=%0d, expected all 0",
               count, disp_val, running, lap_hold, expired, lap_cnt);
    end
    #1;
    rst = 1'b0;
    do_ticks(2);
    vectors++;
    if ({running, count} !== {1'b0, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL async_reset_idle: running=%b count=%0d, expected 0/0", running, count);
    end
  endtask

  initial begin
    $display("[TB] stopwatch_lap_ctrl bench start");
    test_reset();
    test_count_up_wrap();
    test_count_down();
    test_lap_hold();
    test_pause_and_same_cycle();
`ifdef STOPWATCH_LAP_MEM_EN
    test_lap_fifo();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
